axi_lite_serial_adder: RTL

AXI4-Lite slave peripheral that adds or subtracts two OP_W-bit operands with a digit-serial engine, DIGIT_W bits per clock. It generalises the fixed two-bit adder IP to parametrised operand and digit width, and adds a subtract mode, a start/busy/done handshake, carry and overflow flags, and an interrupt. It sits on the processor's S00_AXI GP port and is reached through the block-design wrapper like the existing adder IP.

---
 rtl/axi_lite_serial_adder_if.sv | 34 +++
 rtl/axi_lite_serial_adder.sv | 135 +++++++++++++
 2 files changed

// File: rtl/axi_lite_serial_adder_if.sv
// axi_lite_serial_adder_if: AXI4-Lite bus bundle for the serial adder peripheral
// Ports: parameter ADDR_W sets the byte address width. The master modport drives the
// AW/W/AR channels and BREADY/RREADY. The slave modport drives the ready, response and read-data signals.
interface axi_lite_serial_adder_if #(parameter int ADDR_W = 5);
  logic [ADDR_W-1:0] AWADDR;
  logic [2:0]        AWPROT;
  logic              AWVALID;
  logic              AWREADY;
  logic [31:0]       WDATA;
  logic [3:0]        WSTRB;
  logic              WVALID;
  logic              WREADY;
  logic [1:0]        BRESP;
  logic              BVALID;
  logic              BREADY;
  logic [ADDR_W-1:0] ARADDR;
  logic [2:0]        ARPROT;
  logic              ARVALID;
  logic              ARREADY;
  logic [31:0]       RDATA;
  logic [1:0]        RRESP;
  logic              RVALID;
  logic              RREADY;
  modport master (
    output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    output ARADDR, ARPROT, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
  modport slave (
    input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    input  ARADDR, ARPROT, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axi_lite_serial_adder.sv
// axi_lite_serial_adder: AXI4-Lite peripheral that adds or subtracts two operands, DIGIT_W bits per clock
// Ports:
//   ACLK    - clock, rising edge
//   ARESETN - asynchronous active-low reset
//   s_axi   - AXI4-Lite slave bus with CTRL/STATUS/OPA/OPB/RESULT registers
//   irq     - registered level interrupt, equal to DONE & IRQ_EN
module axi_lite_serial_adder #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int OP_W = 32,
  parameter int DIGIT_W = 2
) (
  input  logic ACLK,
  input  logic ARESETN,
  axi_lite_serial_adder_if.slave s_axi,
  output logic irq
);
  localparam int N = OP_W / DIGIT_W;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN = 1'b1;
  logic [0:0] state;
  logic awready, wr_hs, bvalid, arready, rvalid;
  logic [1:0] bresp;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata;
  logic [31:0] rd_mux, ctrl_w;
  logic sub, irq_en, done, carry, ovf, c;
  logic [OP_W-1:0] opa, opb, result, a_sh, b_sh, res_sh;
  logic [5:0] cnt;
  logic [2:0] wa, ra;
  logic busy, wr_err, wr_ok, start, last, done_n, irq_en_n, c_msb;
  logic [DIGIT_W:0] sum;
  logic [OP_W+DIGIT_W-1:0] res_cat;
  logic unused_ok;
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] strb);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = strb[i] ? wd[8*i +: 8] : old[8*i +: 8];
    return r;
  endfunction
  assign unused_ok = ^{s_axi.AWPROT, s_axi.ARPROT, s_axi.AWADDR[C_S_AXI_ADDR_WIDTH-4:0],
                       s_axi.ARADDR[C_S_AXI_ADDR_WIDTH-4:0]};
  assign wa = s_axi.AWADDR[C_S_AXI_ADDR_WIDTH-1 -: 3];
  assign ra = s_axi.ARADDR[C_S_AXI_ADDR_WIDTH-1 -: 3];
  assign busy = state == RUN;
  assign wr_hs = awready & s_axi.AWVALID & s_axi.WVALID;
  assign ctrl_w = merge({29'b0, irq_en, sub, 1'b0}, s_axi.WDATA, s_axi.WSTRB);
  // STATUS stays writable while busy so DONE can be cleared at any time
  assign wr_err = wr_hs & busy & (wa == 3'd0 | wa == 3'd2 | wa == 3'd3);
  assign wr_ok = wr_hs & ~wr_err;
  assign start = wr_ok & wa == 3'd0 & ctrl_w[0];
  assign last = busy & cnt == 6'(N - 1);
  assign sum = {1'b0, a_sh[DIGIT_W-1:0]} + {1'b0, b_sh[DIGIT_W-1:0]} + {{DIGIT_W{1'b0}}, c};
  assign res_cat = {sum[DIGIT_W-1:0], res_sh};
  // carry into the operand MSB recovered from the top bit of the final digit
  assign c_msb = a_sh[DIGIT_W-1] ^ b_sh[DIGIT_W-1] ^ sum[DIGIT_W-1];
  // completion set has priority over a same-cycle write-1-to-clear
  assign done_n = last | (done & ~start & ~(wr_ok & wa == 3'd1 & s_axi.WDATA[1]));
  assign irq_en_n = (wr_ok & wa == 3'd0) ? ctrl_w[2] : irq_en;
  always_comb begin
    rd_mux = ra == 3'd0 ? {29'b0, irq_en, sub, 1'b0} :
             ra == 3'd1 ? {28'b0, ovf, carry, done, busy} :
             ra == 3'd2 ? 32'(opa) :
             ra == 3'd3 ? 32'(opb) :
             ra == 3'd4 ? 32'(result) : 32'b0;
  end
  assign s_axi.AWREADY = awready;
  assign s_axi.WREADY = awready;
  assign s_axi.BVALID = bvalid;
  assign s_axi.BRESP = bresp;
  assign s_axi.ARREADY = arready;
  assign s_axi.RVALID = rvalid;
  assign s_axi.RDATA = rdata;
  assign s_axi.RRESP = 2'b00;
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      awready <= 1'b0;
      bvalid <= 1'b0;
      bresp <= 2'b00;
      arready <= 1'b0;
      rvalid <= 1'b0;
      rdata <= '0;
    end else begin
      awready <= ~awready & s_axi.AWVALID & s_axi.WVALID & ~bvalid;
      bvalid <= wr_hs | (bvalid & ~s_axi.BREADY);
      if (wr_hs) bresp <= wr_err ? 2'b10 : 2'b00;
      arready <= ~arready & s_axi.ARVALID & ~rvalid;
      rvalid <= arready | (rvalid & ~s_axi.RREADY);
      if (arready) rdata <= rd_mux;
    end
  end
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state <= IDLE;
      sub <= 1'b0;
      irq_en <= 1'b0;
      done <= 1'b0;
      carry <= 1'b0;
      ovf <= 1'b0;
      irq <= 1'b0;
      c <= 1'b0;
      cnt <= '0;
      opa <= '0;
      opb <= '0;
      result <= '0;
      a_sh <= '0;
      b_sh <= '0;
      res_sh <= '0;
    end else begin
      done <= done_n;
      irq_en <= irq_en_n;
      irq <= done_n & irq_en_n;
      if (wr_ok & wa == 3'd0) sub <= ctrl_w[1];
      if (wr_ok & wa == 3'd2) opa <= OP_W'(merge(32'(opa), s_axi.WDATA, s_axi.WSTRB));
      if (wr_ok & wa == 3'd3) opb <= OP_W'(merge(32'(opb), s_axi.WDATA, s_axi.WSTRB));
      if (start) begin
        state <= RUN;
        cnt <= '0;
        c <= ctrl_w[1];
        a_sh <= opa;
        b_sh <= ctrl_w[1] ? ~opb : opb;
      end else if (busy) begin
        cnt <= cnt + 6'd1;
        c <= sum[DIGIT_W];
        a_sh <= a_sh >> DIGIT_W;
        b_sh <= b_sh >> DIGIT_W;
        res_sh <= res_cat[OP_W+DIGIT_W-1:DIGIT_W];
        if (last) begin
          state <= IDLE;
          result <= res_cat[OP_W+DIGIT_W-1:DIGIT_W];
          carry <= sum[DIGIT_W];
          ovf <= c_msb ^ sum[DIGIT_W];
        end
      end
    end
  end
endmodule
